// File: rtl/cmp_seq_ctrl_if.sv
// Handshake bundle for the sequential compare controller.
// Requester drives start/a/b; the controller returns status and flags.
interface cmp_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;

  modport master (
    output start, a, b,
    input  busy, done, a_gt_b, a_lt_b, a_eq_b
  );

  modport slave (
    input  start, a, b,
    output busy, done, a_gt_b, a_lt_b, a_eq_b
  );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// MSB-first magnitude compare, two bits per cycle, one 2-bit slice.
// Exits on the first unequal digit; one-hot flags plus a done pulse.
module comparator_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);
  assign gt = a > b;
  assign lt = a < b;
  assign eq = a == b;
endmodule

module cmp_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cmp_seq_ctrl_if.slave   bus
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIGITS - 1);

  typedef enum logic {
    IDLE,
    CMP
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic             gt_q;
  logic             lt_q;
  logic             eq_q;

  logic             s_gt;
  logic             s_lt;
  logic             s_eq;
  logic             busy;
  logic             load;
  logic             fin;
  logic             shift;

  comparator_2bit u_slice (
    .a  (sa[WIDTH-1:WIDTH-2]),
    .b  (sb[WIDTH-1:WIDTH-2]),
    .gt (s_gt),
    .lt (s_lt),
    .eq (s_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.start) state_n = CMP;
      CMP:  if (fin) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    load  = 1'b0;
    fin   = 1'b0;
    shift = 1'b0;
    unique case (1'b1)
      (state == CMP): begin
        busy  = 1'b1;
        fin   = s_gt | s_lt | (cnt == '0);
        shift = ~fin;
      end
      default: load = bus.start;
    endcase
  end

  // Slice outputs are one-hot, so the final digit's flags are the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
    end else begin
      done_q <= fin;
      if (load) begin
        sa  <= bus.a;
        sb  <= bus.b;
        cnt <= CNT_LOAD;
      end else if (shift) begin
        sa  <= sa << 2;
        sb  <= sb << 2;
        cnt <= cnt - CW'(1);
      end
      if (fin) begin
        gt_q <= s_gt;
        lt_q <= s_lt;
        eq_q <= s_eq;
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done_q;
  assign bus.a_gt_b = gt_q;
  assign bus.a_lt_b = lt_q;
  assign bus.a_eq_b = eq_q;
endmodule
